alu_bist: RTL

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist_if.sv | 24 ++
 rtl/alu_bist.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_bist_if.sv
// Stimulus/response link between the BIST engine and the ALU under test.
// The BIST side drives op code and operands; the ALU side returns result and flags.
interface alu_bist_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CTRL_WIDTH = 3
);
  logic [CTRL_WIDTH-1:0] alu_control;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [WIDTH-1:0]      alu_result;
  logic                  carry;
  logic                  over_flow;
  logic                  zero;

  modport master (
    output alu_control, a, b,
    input  alu_result, carry, over_flow, zero
  );

  modport slave (
    input  alu_control, a, b,
    output alu_result, carry, over_flow, zero
  );
endinterface

// File: rtl/alu_bist.sv
// LFSR-driven ALU self-test: applies NUM_VECTORS pseudo-random vectors, compacts the
// responses into a MISR and compares the final signature against GOLDEN_SIG.
module alu_bist #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      CTRL_WIDTH  = 3,
  parameter int unsigned      NUM_VECTORS = 256,
  parameter logic [WIDTH-1:0] SEED_A      = 32'h1234_5678,
  parameter logic [WIDTH-1:0] SEED_B      = 32'h8765_4321,
  parameter logic [WIDTH-1:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);
  localparam logic [WIDTH-1:0] POLY     = WIDTH'(32'h8020_0003);
  localparam logic [15:0]      LAST_VEC = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [WIDTH-1:0]      lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0]      lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0]      misr_q, misr_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? WIDTH'(1) : s;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l);
    return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] m,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic [2:0]       flags);
    logic [WIDTH-1:0] s;
    s = (m << 1) ^ (m[WIDTH-1] ? POLY : '0);
    return s ^ r ^ WIDTH'(flags);
  endfunction

  // Shift ops only consume a 5-bit shift amount, so operand b is trimmed for them.
  function automatic logic [WIDTH-1:0] mask_b(input logic [WIDTH-1:0]      l,
                                              input logic [CTRL_WIDTH-1:0] op);
    if (op == CTRL_WIDTH'(6) || op == CTRL_WIDTH'(7)) return l & WIDTH'(5'h1f);
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    misr_d   = misr_q;
    ctrl_d   = ctrl_q;
    a_d      = a_q;
    b_d      = b_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          count_d  = '0;
          lfsr_a_d = fix_seed(SEED_A);
          lfsr_b_d = fix_seed(SEED_B);
          misr_d   = '0;
          pass_d   = 1'b0;
          ctrl_d   = '0;
          a_d      = lfsr_a_d;
          b_d      = mask_b(lfsr_b_d, ctrl_d);
        end
      end
      RUN: begin
        misr_d   = misr_step(misr_q, alu.alu_result, {alu.carry, alu.over_flow, alu.zero});
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        if (count_q == LAST_VEC) begin
          state_d = CHECK;
          ctrl_d  = '0;
          a_d     = '0;
          b_d     = '0;
        end else begin
          count_d = count_q + 16'd1;
          ctrl_d  = count_d[CTRL_WIDTH-1:0];
          a_d     = lfsr_a_d;
          b_d     = mask_b(lfsr_b_d, ctrl_d);
        end
      end
      CHECK: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over completion of the last vector and over the CHECK step.
    if (abort && (state_q == RUN || state_q == CHECK)) begin
      state_d = IDLE;
      count_d = '0;
      misr_d  = '0;
      pass_d  = 1'b0;
      ctrl_d  = '0;
      a_d     = '0;
      b_d     = '0;
    end

    busy_d = (state_d == RUN) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      lfsr_a_q <= '0;
      lfsr_b_q <= '0;
      misr_q   <= '0;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      misr_q   <= misr_d;
      ctrl_q   <= ctrl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign alu.alu_control = ctrl_q;
  assign alu.a           = a_q;
  assign alu.b           = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign signature       = misr_q;
endmodule
